fifo_param: RTL and testbench

- Parametrised synchronous FIFO: next generation of the UART-path byte FIFO.
- Generalised data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and write-while-full pass-through.
- Sits between UART RX/TX and the stopwatch/clock command logic; one instance per direction.

---
 rtl/fifo_param.sv | 112 +++++++++++
 tb/tb_fifo_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through FIFO with occupancy count, threshold flags and sticky errors.
// Optional high-water mark on max_count when FIFO_WATERMARK_EN is defined.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   max_count
);

    localparam int AW    = ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         w_ptr;
    logic [AW-1:0]         r_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  overflow_q;
    logic                  underflow_q;

    // Flags come straight from the count register.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign rdata        = mem[r_ptr];

    // A read on a full FIFO frees the slot the write lands in.
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;

    always_comb begin
        count_nxt = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + AW'(1);
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + AW'(1);
            end
            count_q     <= count_nxt;
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow_q  <= (wr & ~wr_ok) | (overflow_q & ~clr_err);
            underflow_q <= (rd & empty) | (underflow_q & ~clr_err);
        end
    end

`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (clr_err) begin
            max_q <= count_nxt;
        end else if (count_nxt > max_q) begin
            max_q <= count_nxt;
        end
    end

    assign max_count = max_q;
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: queue-based reference model checked every cycle, plus literal
// expectations along the stimulus sequence. Define FIFO_WATERMARK_EN to exercise the high-water mark.
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          rd;
    logic          clr_err;
    logic          full;
    logic          almost_full;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [AW:0]   max_count;

    int n_vec = 0;
    int n_err = 0;

    fifo_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wdata       (wdata),
        .wr          (wr),
        .full        (full),
        .almost_full (almost_full),
        .rd          (rd),
        .rdata       (rdata),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err),
        .max_count   (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags from queue size.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_unf;
    int            m_max;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            m_max = 0;
        end else begin
            int  sz;
            bit  wok;
            bit  rok;
            sz  = mq.size();
            wok = wr && ((sz < DEPTH) || rd);
            rok = rd && (sz > 0);
            if (rok) void'(mq.pop_front());
            if (wok) mq.push_back(wdata);
            m_ovf = (wr && !wok) || (m_ovf && !clr_err);
            m_unf = (rd && sz == 0) || (m_unf && !clr_err);
`ifdef FIFO_WATERMARK_EN
            if (clr_err) m_max = mq.size();
            else if (mq.size() > m_max) m_max = mq.size();
`else
            m_max = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 32'(count), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("almost_full", 32'(almost_full), 32'(mq.size() >= 14));
            check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
            check("max_count", 32'(max_count), 32'(m_max));
            if (mq.size() > 0) check("rdata", 32'(rdata), 32'(mq[0]));
        end
    end

    task automatic op(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        @(negedge clk);
        #1;
        wr = w; wdata = d; rd = r; clr_err = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    int exp_hi;
    int exp_clr;

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_max", 32'(max_count), 0);

        // Fill with 0x11..0x1F, then 0x20.
        for (int i = 0; i < 15; i++) begin
            op(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            if (i == 12) check("af_at13", 32'(almost_full), 0);
            if (i == 13) check("af_at14", 32'(almost_full), 1);
        end
        check("cnt15", 32'(count), 15);
        check("full15", 32'(full), 0);
        op(1'b1, 8'h20, 1'b0, 1'b0);
        check("full16", 32'(full), 1);
        check("cnt16", 32'(count), 16);

        // Overflow, then drain in order.
        op(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_cnt", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(rdata), 32'(8'h11 + i));
            op(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 12) check("ae_at3", 32'(almost_empty), 0);
            if (i == 13) check("ae_at2", 32'(almost_empty), 1);
        end
        check("drained_empty", 32'(empty), 1);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        // Simultaneous read/write on empty.
        op(1'b1, 8'hA5, 1'b1, 1'b0);
        check("wr_rd_empty_cnt", 32'(count), 1);
        check("wr_rd_empty_unf", 32'(underflow), 1);
        check("wr_rd_empty_data", 32'(rdata), 32'h A5);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 0);
        op(1'b0, 8'h00, 1'b1, 1'b0);

        // Full pass-through with pointer wrap.
        for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        wr = 1'b1; rd = 1'b1; wdata = 8'hEE;
        #1;
        check("pass_head", 32'(rdata), 32'h00);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
        check("pass_cnt", 32'(count), 16);
        check("pass_full", 32'(full), 1);
        check("pass_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            check("wrap_data", 32'(rdata), (i == 16) ? 32'hEE : i);
            op(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-cycle.
        op(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(count), 5);
        check("pre_rst_unf", 32'(underflow), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 1);
        check("arst_cnt", 32'(count), 0);
        check("arst_unf", 32'(underflow), 0);
        check("arst_ae", 32'(almost_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst_data", 32'(rdata), 32'h77);
        check("post_rst_cnt", 32'(count), 1);

        // High-water mark.
        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) op(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
`ifdef FIFO_WATERMARK_EN
        exp_hi  = 9;
        exp_clr = 3;
`else
        exp_hi  = 0;
        exp_clr = 0;
`endif
        check("max_hi", 32'(max_count), 32'(exp_hi));
        op(1'b0, 8'h00, 1'b0, 1'b1);
        check("max_clr", 32'(max_count), 32'(exp_clr));
        check("wm_cnt", 32'(count), 3);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
